serial_pattern_tx: RTL and testbench

Parallel-to-serial pattern transmitter that drives the single-bit serial input `X` of the lab-08 run/fall detector FSMs. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per clock. Each frame ends with a guard gap of zeros, so the detector always sees a terminating 0. It also reports the detector-side state the stream should produce: the Gray-coded run-of-ones count and the number of 1→0 falls per frame. The verification bench uses these to check the detector's `A`, `B` and `Y` against the transmitter.

---
 rtl/serial_pattern_tx_if.sv | 17 +
 rtl/serial_pattern_tx.sv | 158 +++++++++++++++
 tb/tb_serial_pattern_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_tx_if.sv
// serial_pattern_tx_if
// Load handshake between a word producer and serial_pattern_tx.
//   data_in : payload word, sampled only on an accepted load
//   load    : valid strobe for data_in
//   ready   : transmitter can take a word this cycle
// Handshake: a word transfers on a rising clock edge where load && ready.
// A load seen while ready is low is dropped, not queued.
interface serial_pattern_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;

    modport master (output data_in, output load, input ready);
    modport slave  (input data_in, input load, output ready);
endinterface

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
// Parallel-to-serial pattern transmitter feeding a run/fall detector.
// A WIDTH-bit word taken over the load handshake is shifted out MSB first
// on X, followed by GAP_LEN forced-zero guard cycles. Alongside the stream
// it reports the Gray run-of-ones count the detector should hold and the
// number of 1->0 falls seen in the current frame.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   bus            : load handshake (data_in, load, ready)
//   X              : registered serial output
//   busy           : high in SHIFT or GAP
//   frame_done     : pulse in the last gap cycle of a frame
//   run            : Gray run count 00->01->11->10 (saturating)
//   edge_cnt       : 1->0 falls on X in the current frame
//   state_dbg      : current FSM state (0 IDLE, 1 SHIFT, 2 GAP)
module serial_pattern_tx #(
    parameter int WIDTH   = 8,
    parameter int GAP_LEN = 1,
    parameter int CW      = $clog2(WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    serial_pattern_tx_if.slave    bus,
    output logic                  X,
    output logic                  busy,
    output logic                  frame_done,
    output logic [1:0]            run,
    output logic [CW-1:0]         edge_cnt,
    output logic [1:0]            state_dbg
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = $clog2(GAP_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             x_q, x_d;
    logic [1:0]       run_q, run_d;
    logic [CW-1:0]    edge_q, edge_d;

    logic last_gap;
    logic ready_int;
    logic accept;

    assign last_gap = (state_q == ST_GAP) && (gap_cnt_q == GW'(GAP_LEN - 1));
    assign accept   = bus.load && ready_int;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            x_q       <= 1'b0;
            run_q     <= 2'b00;
            edge_q    <= '0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            x_q       <= x_d;
            run_q     <= run_d;
            edge_q    <= edge_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        x_d       = 1'b0;
        edge_d    = edge_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SHIFT;
                    x_d       = bus.data_in[WIDTH-1];
                    sreg_d    = {bus.data_in[WIDTH-2:0], 1'b0};
                    bit_cnt_d = BW'(WIDTH - 1);
                end
            end
            ST_SHIFT: begin
                // bit_cnt_q counts the bits still to present after the current one
                if (bit_cnt_q == '0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end else begin
                    x_d       = sreg_q[WIDTH-1];
                    sreg_d    = {sreg_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (last_gap) begin
                    if (accept) begin
                        state_d   = ST_SHIFT;
                        x_d       = bus.data_in[WIDTH-1];
                        sreg_d    = {bus.data_in[WIDTH-2:0], 1'b0};
                        bit_cnt_d = BW'(WIDTH - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Fall counting only inside a frame; IDLE holds the final count
        if ((state_q != ST_IDLE) && x_q && !x_d) begin
            edge_d = edge_q + 1'b1;
        end
        if (accept) begin
            edge_d = '0;
        end
    end

    // Run tracker follows the bit being driven so it lines up with X
    always_comb begin
        run_d = 2'b00;
        if (x_d) begin
            case (run_q)
                2'b00:   run_d = 2'b01;
                2'b01:   run_d = 2'b11;
                default: run_d = 2'b10;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        ready_int  = (state_q == ST_IDLE) || last_gap;
        busy       = (state_q == ST_SHIFT) || (state_q == ST_GAP);
        frame_done = last_gap;
    end

    assign bus.ready = ready_int;
    assign X         = x_q;
    assign run       = run_q;
    assign edge_cnt  = edge_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
module tb_serial_pattern_tx;
    localparam int WIDTH   = 8;
    localparam int GAP_LEN = 1;
    localparam int CW      = $clog2(WIDTH + 1);
    localparam int FL      = WIDTH + GAP_LEN;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    serial_pattern_tx_if #(.WIDTH(WIDTH)) bus ();

    logic          X;
    logic          busy;
    logic          frame_done;
    logic [1:0]    run;
    logic [CW-1:0] edge_cnt;
    logic [1:0]    state_dbg;

    serial_pattern_tx #(.WIDTH(WIDTH), .GAP_LEN(GAP_LEN)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .X          (X),
        .busy       (busy),
        .frame_done (frame_done),
        .run        (run),
        .edge_cnt   (edge_cnt),
        .state_dbg  (state_dbg)
    );

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is the word's bits MSB first followed by GAP_LEN zeros;
    // the model only tracks which position of that sequence is on X.
    bit               m_idle = 1'b1;
    int               m_pos = 0;
    logic [WIDTH-1:0] m_word = '0;
    logic             m_x = 1'b0;
    int               m_run_len = 0;
    int               m_edge = 0;

    function automatic logic frame_bit(input logic [WIDTH-1:0] w, input int k);
        return (k < WIDTH) ? w[WIDTH-1-k] : 1'b0;
    endfunction

    function automatic int falls_upto(input logic [WIDTH-1:0] w, input int pos);
        int n = 0;
        for (int i = 0; i < pos; i++)
            if (frame_bit(w, i) && !frame_bit(w, i + 1)) n++;
        return n;
    endfunction

    function automatic logic [1:0] gray_run(input int len);
        if (len == 0) return 2'b00;
        if (len == 1) return 2'b01;
        if (len == 2) return 2'b11;
        return 2'b10;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_idle = 1'b1; m_pos = 0; m_word = '0; m_x = 1'b0;
            m_run_len = 0; m_edge = 0;
        end else begin
            if ((m_idle || m_pos == FL - 1) && bus.load) begin
                m_word = bus.data_in; m_idle = 1'b0; m_pos = 0;
            end else if (!m_idle) begin
                if (m_pos == FL - 1) m_idle = 1'b1;
                else m_pos++;
            end
            m_x = m_idle ? 1'b0 : frame_bit(m_word, m_pos);
            m_run_len = m_x ? m_run_len + 1 : 0;
            if (!m_idle) m_edge = falls_upto(m_word, m_pos);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (checking && reset_n) begin
            chk("x", X, m_x);
            chk("ready", bus.ready, m_idle || m_pos == FL - 1);
            chk("busy", busy, !m_idle);
            chk("frame_done", frame_done, !m_idle && m_pos == FL - 1);
            chk("run", run, gray_run(m_run_len));
            chk("edge_cnt", edge_cnt, m_edge);
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after a rising edge.
    task automatic drive(input logic ld, input logic [WIDTH-1:0] d);
        @(posedge clock); #2;
        bus.load = ld; bus.data_in = d;
    endtask

    // Single frame from idle with literal per-cycle expectations
    task automatic frame_lit(input logic [WIDTH-1:0] w, input logic [8:0] ex,
                             input logic [17:0] er, input int ee, input string tag);
        drive(1'b1, w);
        @(posedge clock); #2;
        bus.load = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            chk({tag, "_x"}, X, ex[9-c]);
            chk({tag, "_run"}, run, er[(9-c)*2 +: 2]);
        end
        chk({tag, "_done"}, frame_done, 1'b1);
        chk({tag, "_edge"}, edge_cnt, ee);
    endtask

    logic [WIDTH-1:0] word_tab [6];

    initial begin
        bus.load = 1'b0;
        bus.data_in = '0;
        word_tab[0] = 8'h00; word_tab[1] = 8'h55; word_tab[2] = 8'h80;
        word_tab[3] = 8'h01; word_tab[4] = 8'hC3; word_tab[5] = 8'h7E;

        // reset values
        #12;
        chk("rst_x", X, 1'b0);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_edge", edge_cnt, 0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        checking = 1'b1;

        // idle
        repeat (10) @(posedge clock);

        frame_lit(8'b1011_0010, 9'b101100100,
                  {2'b01, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00}, 3, "b2");
        frame_lit(8'hFF, 9'b111111110,
                  {2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00}, 1, "ff");
        repeat (3) @(posedge clock);

        // back-to-back A5 then 0F with load held
        drive(1'b1, 8'hA5);
        @(posedge clock); #2;
        bus.data_in = 8'h0F;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clock);
            if (c == 9) begin
                chk("b2b_done1", frame_done, 1'b1);
                chk("b2b_edge1", edge_cnt, 4);
                @(posedge clock); #2;
                bus.load = 1'b0;
            end
            if (c == 10) begin
                chk("b2b_busy10", busy, 1'b1);
                chk("b2b_edge10", edge_cnt, 0);
            end
            if (c == 14) chk("b2b_x14", X, 1'b1);
            if (c == 18) begin
                chk("b2b_done2", frame_done, 1'b1);
                chk("b2b_edge2", edge_cnt, 1);
            end
        end
        repeat (2) @(posedge clock);

        // ignored load mid-frame, then reset mid-frame
        drive(1'b1, 8'b1011_1110);
        @(posedge clock); #2;
        bus.load = 1'b0;
        @(negedge clock);
        @(negedge clock);
        drive(1'b1, 8'h40);
        @(negedge clock);
        chk("ign_x3", X, 1'b1);
        drive(1'b0, 8'h40);
        @(negedge clock);
        chk("ign_x4", X, 1'b1);
        chk("ign_busy4", busy, 1'b1);
        @(posedge clock); #2;
        chk("pre_rst_x5", X, 1'b1);
        chk("pre_rst_run5", run, 2'b10);
        reset_n = 1'b0;
        #1;
        chk("arst_x", X, 1'b0);
        chk("arst_ready", bus.ready, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", frame_done, 1'b0);
        chk("arst_run", run, 2'b00);
        chk("arst_edge", edge_cnt, 0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clock);
        frame_lit(8'b1011_0010, 9'b101100100,
                  {2'b01, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00}, 3, "post_rst");

        // directed word table, back-to-back, checked by the model
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, word_tab[i]);
            repeat (FL - 1) @(posedge clock);
        end
        drive(1'b0, '0);
        repeat (FL + 4) @(posedge clock);

        // table again with idle cycles between frames
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, word_tab[5 - i]);
            drive(1'b0, '0);
            repeat (FL + i) @(posedge clock);
        end
        repeat (4) @(posedge clock);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
